// File: rtl/audio_pkg.sv
// Shared audio types and constants for the mixer/DSP chain and the I2S transmitter.
package audio_pkg;
  localparam int SAMPLE_W       = 16;
  localparam int I2S_FRAME_BITS = 2 * SAMPLE_W;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic int i2s_frame_bits(input int width);
    return 2 * width;
  endfunction
endpackage

// File: rtl/i2s_tx_if.sv
// Mixed audio packet stream: sample bus plus one-cycle "changed" strobe.
interface i2s_tx_if #(
  parameter int WIDTH = audio_pkg::SAMPLE_W
);
  logic [WIDTH-1:0] pktMixed;
  logic             pktMixedChanged;

  modport master (output pktMixed, output pktMixedChanged);
  modport slave  (input  pktMixed, input  pktMixedChanged);
endinterface

// File: rtl/i2s_clk_gen.sv
// BCLK divider with a fall-event strobe and the per-frame bit counter.
module i2s_clk_gen #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = audio_pkg::I2S_FRAME_BITS,
  localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1,
  localparam int CNT_W     = $clog2(FRAME_BITS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_bclk,
  output logic             o_fall,
  output logic [CNT_W-1:0] o_bit_cnt
);
  logic [DIV_W-1:0] r_div;
  logic             r_bclk;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             w_div_end;
  logic             w_fall;

  assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_fall    = w_div_end & r_bclk;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div     <= '0;
      r_bclk    <= 1'b0;
      r_bit_cnt <= '0;
    end else begin
      if (w_div_end) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div <= r_div + 1'b1;
      end
      if (w_fall) begin
        r_bit_cnt <= (r_bit_cnt == CNT_W'(FRAME_BITS - 1)) ? '0 : r_bit_cnt + 1'b1;
      end
    end
  end

  assign o_bclk    = r_bclk;
  assign o_fall    = w_fall;
  assign o_bit_cnt = r_bit_cnt;
endmodule

// File: rtl/i2s_tx.sv
// Mono-to-stereo I2S master transmitter with a one-entry pending sample
// and underrun/overrun flags.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int WIDTH   = SAMPLE_W,
  parameter int CLK_DIV = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  i2s_tx_if.slave  pkt_if,
  output logic     bclk_o,
  output logic     lrclk_o,
  output logic     sd_o,
  output logic     frameStart_o,
  output logic     underrun_o,
  output logic     overrun_o
);
  localparam int FRAME_BITS = i2s_frame_bits(WIDTH);
  localparam int CNT_W      = $clog2(FRAME_BITS);

  logic                  w_bclk;
  logic                  w_fall;
  logic [CNT_W-1:0]      w_bit_cnt;
  logic                  w_frame_start;
  logic [CNT_W-1:0]      w_sd_idx;

  logic [WIDTH-1:0]      r_pending;
  logic                  r_fresh;
  logic                  r_first;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_lrclk;
  logic                  r_sd;
  logic                  r_frame_start;
  logic                  r_underrun;
  logic                  r_overrun;

  i2s_clk_gen #(
    .CLK_DIV    (CLK_DIV),
    .FRAME_BITS (FRAME_BITS)
  ) u_clk_gen (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .o_bclk    (w_bclk),
    .o_fall    (w_fall),
    .o_bit_cnt (w_bit_cnt)
  );

  assign w_frame_start = w_fall && (w_bit_cnt == '0);
  // One-bit I2S delay: at bit k send frame bit k-1; at k=0 the old shift's LSB
  // (previous right-word LSB) goes out while the new word loads.
  assign w_sd_idx = (w_bit_cnt == '0) ? '0 : CNT_W'(FRAME_BITS) - w_bit_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending     <= '0;
      r_fresh       <= 1'b0;
      r_first       <= 1'b1;
      r_shift       <= '0;
      r_lrclk       <= 1'b1;
      r_sd          <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_overrun     <= 1'b0;
      if (w_fall) begin
        r_lrclk <= (w_bit_cnt >= CNT_W'(WIDTH));
        r_sd    <= r_shift[w_sd_idx];
      end
      if (w_frame_start) begin
        r_shift       <= {r_pending, r_pending};
        r_fresh       <= 1'b0;
        r_first       <= 1'b0;
        r_frame_start <= 1'b1;
        r_underrun    <= ~r_fresh & ~r_first;
      end
      // Capture after the load so a coincident strobe survives as fresh.
      if (pkt_if.pktMixedChanged) begin
        r_pending <= pkt_if.pktMixed;
        r_fresh   <= 1'b1;
        r_overrun <= r_fresh & ~w_frame_start;
      end
    end
  end

  assign bclk_o       = w_bclk;
  assign lrclk_o      = r_lrclk;
  assign sd_o         = r_sd;
  assign frameStart_o = r_frame_start;
  assign underrun_o   = r_underrun;
  assign overrun_o    = r_overrun;
endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: randomized strobe schedule, frame-window reference model.
module tb_i2s_tx;
  import audio_pkg::*;

  localparam int W    = SAMPLE_W;
  localparam int CD   = 2;
  localparam int FB   = 2 * W;
  localparam int FC   = 2 * FB * CD;
  localparam int T0   = 2 * CD;
  localparam int NCYC = 2400;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bclk, lrclk, sd, fs, ur, ov;

  i2s_tx_if #(.WIDTH(W)) pkt_if ();

  i2s_tx #(.WIDTH(W), .CLK_DIV(CD)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pkt_if       (pkt_if),
    .bclk_o       (bclk),
    .lrclk_o      (lrclk),
    .sd_o         (sd),
    .frameStart_o (fs),
    .underrun_o   (ur),
    .overrun_o    (ov)
  );

  always #5 clk = ~clk;

  int cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else     cnt <= cnt + 1;
  end

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_bclk"},  bclk,  0);
    check({tag, "_lrclk"}, lrclk, 1);
    check({tag, "_sd"},    sd,    0);
    check({tag, "_fs"},    fs,    0);
    check({tag, "_ur"},    ur,    0);
    check({tag, "_ov"},    ov,    0);
  endtask

  // Number of frame starts at or before cycle x.
  function automatic int nst(input int x);
    return (x < T0) ? 0 : (x - T0) / FC + 1;
  endfunction

  logic [W-1:0] q_w[$];
  int           q_t[$];
  bit           q_u[$];
  int           q_ov[$];

  bit           sched_s [0:NCYC];
  logic [W-1:0] sched_v [0:NCYC];

  bit           mon_en = 1'b0;
  int           rise;
  logic         prev_b;
  logic [W-1:0] acc;
  logic         lr0;

  // Monitor: frame pulses, flags and serial words, all sampled on the falling clk edge.
  initial begin
    int s;
    rise = 0; prev_b = 1'b0; acc = '0; lr0 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rise = 0;
        prev_b = 1'b0;
      end else if (mon_en) begin
        if (fs) begin
          if (q_t.size() == 0) check("fs_extra", 1, 0);
          else begin
            check("fs_cycle", cnt, q_t.pop_front());
            check("underrun", ur, q_u.pop_front());
          end
        end else if (ur) begin
          check("underrun_lone", 1, 0);
        end
        if (ov) begin
          if (q_ov.size() == 0) check("overrun_extra", cnt, 0);
          else check("overrun_cycle", cnt, q_ov.pop_front());
        end
        if (bclk && !prev_b) begin
          if (rise >= 2) begin
            s = rise - 2;
            if (s % W == 0) begin
              acc = '0;
              lr0 = lrclk;
            end
            acc = {acc[W-2:0], sd};
            if (s % W == W - 1) begin
              if (q_w.size() == 0) check("word_extra", acc, 0);
              else check("word", acc, q_w.pop_front());
              check("lrclk_slot", lr0, (s / W) % 2);
            end
          end
          rise++;
        end
        prev_b = bclk;
      end
    end
  end

  task automatic build_model();
    int last_c;
    int t;
    logic [W-1:0] word;
    bit any;
    last_c = -1;
    for (int c = 1; c <= NCYC; c++) begin
      if (sched_s[c]) begin
        if (last_c >= 0 && nst(c) == nst(last_c)) q_ov.push_back(c);
        last_c = c;
      end
    end
    for (int n = 0; T0 + n * FC <= NCYC; n++) begin
      t = T0 + n * FC;
      word = '0;
      any = 1'b0;
      for (int c = 1; c < t; c++) if (sched_s[c]) word = sched_v[c];
      if (n > 0) for (int c = t - FC; c < t; c++) if (sched_s[c]) any = 1'b1;
      q_t.push_back(t);
      q_u.push_back((n > 0) && !any);
      for (int w = 2 * n; w <= 2 * n + 1; w++)
        if (CD * (1 + 2 * (W * (w + 1) + 1)) <= NCYC) q_w.push_back(word);
    end
  endtask

  initial begin
    int guard;
    pkt_if.pktMixed = '0;
    pkt_if.pktMixedChanged = 1'b0;

    for (int c = 0; c <= NCYC; c++) begin
      sched_s[c] = 1'b0;
      sched_v[c] = '0;
    end
    sched_s[1]   = 1'b1; sched_v[1]   = 16'hA5C3;
    sched_s[140] = 1'b1; sched_v[140] = 16'h1234;
    sched_s[200] = 1'b1; sched_v[200] = 16'h8001;
    sched_s[300] = 1'b1; sched_v[300] = 16'h0001;
    sched_s[388] = 1'b1; sched_v[388] = 16'h7FFF;
    for (int c = 600; c <= NCYC - 20; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        sched_s[c] = 1'b1;
        sched_v[c] = W'($urandom);
      end
    end
    for (int n = 5; T0 + n * FC <= NCYC - 20; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        sched_s[T0 + n * FC] = 1'b1;
        sched_v[T0 + n * FC] = W'($urandom);
      end
    end
    build_model();

    #1 rst = 1'b1;
    #3 check_reset("reset");
    repeat (3) @(posedge clk);
    check_reset("reset_clocked");
    @(negedge clk);
    mon_en = 1'b1;
    rst = 1'b0;
    for (int c = 1; c <= NCYC; c++) begin
      pkt_if.pktMixed = sched_v[c];
      pkt_if.pktMixedChanged = sched_s[c];
      @(posedge clk);
      #1;
    end
    pkt_if.pktMixedChanged = 1'b0;
    @(negedge clk);
    #1 mon_en = 1'b0;
    check("fs_left",      q_t.size(),  0);
    check("overrun_left", q_ov.size(), 0);
    check("word_left",    q_w.size(),  0);

    // Asynchronous reset in the middle of frame bit 20, while BCLK is high.
    guard = 0;
    while (cnt != T0 + 19 * FC + 20 * 2 * CD + CD && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("midreset_reached", guard < 1000, 1);
    check("midreset_bclk_pre", bclk, 1);
    #1 rst = 1'b1;
    #1 check_reset("midreset");
    repeat (3) @(posedge clk);

    q_t.push_back(T0);      q_u.push_back(1'b0);
    q_t.push_back(T0 + FC); q_u.push_back(1'b1);
    q_w.push_back('0);
    q_w.push_back('0);
    @(negedge clk);
    mon_en = 1'b1;
    rst = 1'b0;
    for (int c = 1; c <= 140; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) check("bclk_c1", bclk, 0);
      if (c == 2) check("bclk_c2", bclk, 1);
      if (c == 4) check("bclk_c4", bclk, 0);
    end
    @(negedge clk);
    #1 mon_en = 1'b0;
    check("p2_fs_left",   q_t.size(),  0);
    check("p2_word_left", q_w.size(),  0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
